// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the two-way cache controller: FSM states,
// way index type and the victim-way selection rule.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_FILL  = 3'd2,
    ST_RETRY = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  typedef logic way_idx_t;

  // An empty way is always preferred so a clean fill never evicts live data.
  function automatic way_idx_t pick_victim(input logic [1:0] valid, input way_idx_t victimway);
    if (!valid[0])      return 1'b0;
    else if (!valid[1]) return 1'b1;
    else                return victimway;
  endfunction

  function automatic logic [1:0] way_onehot(input way_idx_t w);
    return w ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_ctrl_2way_if.sv
// Bundle of pipeline, cache-array and memory signals around the controller.
// The slave side is the controller; the master side is its environment.
interface cache_ctrl_2way_if #(parameter int WORDS = 4);
  localparam int OW = $clog2(WORDS);

  logic          rd;
  logic          wr;
  logic [1:0]    hit;
  logic [1:0]    valid;
  logic [1:0]    dirty;
  logic          cache_err;
  logic          mem_err;
  logic          mem_stall;
  logic [1:0]    way_en;
  logic          comp;
  logic          cache_wr;
  logic [OW-1:0] cache_word;
  logic          mem_rd;
  logic          mem_wr;
  logic [OW-1:0] mem_word;
  logic          use_victim_tag;
  logic          stall;
  logic          done;
  logic          cache_hit;
  logic          err;

  modport slave (
    input  rd, wr, hit, valid, dirty, cache_err, mem_err, mem_stall,
    output way_en, comp, cache_wr, cache_word, mem_rd, mem_wr, mem_word,
           use_victim_tag, stall, done, cache_hit, err
  );

  modport master (
    output rd, wr, hit, valid, dirty, cache_err, mem_err, mem_stall,
    input  way_en, comp, cache_wr, cache_word, mem_rd, mem_wr, mem_word,
           use_victim_tag, stall, done, cache_hit, err
  );
endinterface

// File: rtl/mem_return_pipe.sv
// Tracks accepted memory reads through the fixed memory latency; a set bit
// leaving the last stage marks a returning data word.
module mem_return_pipe #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic accept_i,
  output logic ret_valid_o
);

  logic [MEM_LAT-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = accept_i;
    if (flush_i) pipe_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign ret_valid_o = pipe_q[MEM_LAT-1];

endmodule

// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative write-back/write-allocate L1 controller. Line
// write-back and refill are sequenced by word counters instead of per-word states.
module cache_ctrl_2way
  import cache_ctrl_pkg::*;
#(
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  cache_ctrl_2way_if.slave bus
);

  localparam int OW = $clog2(WORDS);
  localparam int CW = OW + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] TERM = CW'(WORDS);

  state_e          state_q, state_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
  way_idx_t        victimway_q, victimway_d;
  way_idx_t        vict_q, vict_d;
  logic            op_wr_q, op_wr_d;

  logic            req, any_err, rd_accept, ret_valid, flush;
  logic [1:0]      hit_vec;
  way_idx_t        vsel;

  logic [1:0]      way_en;
  logic            comp, cache_wr, mem_rd, mem_wr, use_vt, stall, done, cache_hit, err;
  logic [OW-1:0]   cache_word, mem_word;

  assign req       = bus.rd | bus.wr;
  assign any_err   = bus.cache_err | bus.mem_err;
  assign hit_vec   = bus.hit & bus.valid;
  assign vsel      = pick_victim(bus.valid, victimway_q);
  assign rd_accept = mem_rd & ~bus.mem_stall;
  assign flush     = (state_d == ST_ERR);

  mem_return_pipe #(.MEM_LAT(MEM_LAT)) u_ret (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .accept_i   (rd_accept),
    .ret_valid_o(ret_valid)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    vict_d      = vict_q;
    op_wr_d     = op_wr_q;
    way_en      = 2'b00;
    comp        = 1'b1;
    cache_wr    = 1'b0;
    cache_word  = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_word    = '0;
    use_vt      = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    cache_hit   = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          way_en = 2'b11;
          if (any_err) begin
            stall   = 1'b1;
            state_d = ST_ERR;
          end else if (|hit_vec) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            way_en    = hit_vec[0] ? 2'b01 : 2'b10;
            cache_wr  = bus.wr;
          end else begin
            stall       = 1'b1;
            op_wr_d     = bus.wr;
            vict_d      = vsel;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            state_d     = (bus.valid[vsel] & bus.dirty[vsel]) ? ST_WB : ST_FILL;
          end
        end
      end

      ST_WB: begin
        comp       = 1'b0;
        way_en     = way_onehot(vict_q);
        use_vt     = 1'b1;
        mem_wr     = 1'b1;
        stall      = 1'b1;
        cache_word = issue_cnt_q[OW-1:0];
        mem_word   = issue_cnt_q[OW-1:0];
        if (!bus.mem_stall) begin
          if (issue_cnt_q == LAST) begin
            issue_cnt_d = '0;
            state_d     = ST_FILL;
          end else begin
            issue_cnt_d = issue_cnt_q + 1'b1;
          end
        end
      end

      ST_FILL: begin
        stall = 1'b1;
        if (issue_cnt_q < TERM) begin
          mem_rd   = 1'b1;
          mem_word = issue_cnt_q[OW-1:0];
          if (!bus.mem_stall) issue_cnt_d = issue_cnt_q + 1'b1;
        end
        // A return arriving alongside an error is dropped: the line is being abandoned.
        if (ret_valid && !any_err) begin
          cache_wr   = 1'b1;
          comp       = 1'b0;
          way_en     = way_onehot(vict_q);
          cache_word = ret_cnt_q[OW-1:0];
          if (ret_cnt_q == LAST) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            state_d     = ST_RETRY;
          end else begin
            ret_cnt_d = ret_cnt_q + 1'b1;
          end
        end
      end

      ST_RETRY: begin
        way_en   = way_onehot(vict_q);
        cache_wr = op_wr_q;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end

      ST_ERR: begin
        err         = 1'b1;
        done        = 1'b1;
        stall       = 1'b1;
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && state_q != ST_ERR && any_err) begin
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
      state_d     = ST_ERR;
    end
  end

  assign victimway_d = victimway_q ^ done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      victimway_q <= 1'b0;
      vict_q      <= 1'b0;
      op_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      victimway_q <= victimway_d;
      vict_q      <= vict_d;
      op_wr_q     <= op_wr_d;
    end
  end

  assign bus.way_en         = way_en;
  assign bus.comp           = comp;
  assign bus.cache_wr       = cache_wr;
  assign bus.cache_word     = cache_word;
  assign bus.mem_rd         = mem_rd;
  assign bus.mem_wr         = mem_wr;
  assign bus.mem_word       = mem_word;
  assign bus.use_victim_tag = use_vt;
  assign bus.stall          = stall;
  assign bus.done           = done;
  assign bus.cache_hit      = cache_hit;
  assign bus.err            = err;

endmodule
